// File: rtl/dec_to_bin_pkg.sv
// Shared FSM encoding, digit-correction constants and width mapping for dec_to_bin.
package dec_to_bin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_SUB3,
      ST_DONE
   } state_t;

   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_SUB    = 4'd3;

   // Wide enough to count the largest conversion (14 steps).
   localparam int STEP_W = 4;

   function automatic int bin_w(input int ndig);
      int w;
      case (ndig)
         1:       w = 4;
         2:       w = 7;
         3:       w = 10;
         default: w = 14;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit field: subtract 3 when the field is 8 or more.
module bcd_digit_adj
   import dec_to_bin_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= ADJ_THRESH) ? (din - ADJ_SUB) : din;

endmodule

// File: rtl/dec_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result per 2*BIN_W+1 cycles.
// Optional DEC_TO_BIN_RANGE_CHECK_EN: digits > 9 short-circuit to done with err=1, bin=0.
module dec_to_bin
   import dec_to_bin_pkg::*;
#(
   parameter  int NDIG  = 3,
   localparam int BIN_W = bin_w(NDIG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4*NDIG-1:0] bcd,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [BIN_W-1:0]  bin,
   output logic              err
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);

   state_t              state_q, state_d;
   logic [4*NDIG-1:0]   dig_q, dig_d;
   logic [BIN_W-1:0]    acc_q, acc_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic                bad_q, bad_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [4*NDIG-1:0]   dig_adj;
   logic                bad_digit;

   for (genvar i = 0; i < NDIG; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (dig_q[4*i +: 4]),
         .dout (dig_adj[4*i +: 4])
      );
   end

`ifdef DEC_TO_BIN_RANGE_CHECK_EN
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end
`else
   assign bad_digit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      acc_d   = acc_q;
      step_d  = step_q;
      bin_d   = bin_q;
      bad_d   = bad_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dig_d   = bcd;
               acc_d   = '0;
               step_d  = '0;
               bad_d   = bad_digit;
               state_d = bad_digit ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // The digit chain and accumulator form one long right-shift register.
            {dig_d, acc_d} = {1'b0, dig_q, acc_q[BIN_W-1:1]};
            step_d  = step_q + 1'b1;
            state_d = (step_q == LAST_STEP) ? ST_DONE : ST_SUB3;
         end
         ST_SUB3: begin
            dig_d   = dig_adj;
            state_d = ST_SHIFT;
         end
         ST_DONE: begin
            bin_d   = acc_q;
            err_d   = bad_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dig_q   <= '0;
         acc_q   <= '0;
         step_q  <= '0;
         bin_q   <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         bin_q   <= bin_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bin  = bin_q;
   assign err  = err_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// Self-checking bench for dec_to_bin (NDIG=3): scoreboard of expected results, popped on each done.
module tb_dec_to_bin;

   localparam int NDIG  = 3;
   localparam int BIN_W = 10;

   typedef struct packed {
      logic [BIN_W-1:0] bin;
      logic             err;
   } exp_t;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [4*NDIG-1:0] bcd   = '0;
   logic              busy, done, err;
   logic [BIN_W-1:0]  bin;

   exp_t sb[$];
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   t_start  = 0;

   dec_to_bin #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bcd   (bcd),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bin   (bin),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Reference: plain decimal value of the packed digits.
   function automatic exp_t model(input logic [4*NDIG-1:0] v);
      exp_t       e;
      int         val;
      logic       bad;
      logic [3:0] d;
      val = 0;
      bad = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         if (d > 4'd9) bad = 1'b1;
         val = val * 10 + int'(d);
      end
`ifdef DEC_TO_BIN_RANGE_CHECK_EN
      e.bin = bad ? '0 : BIN_W'(val);
      e.err = bad;
`else
      e.bin = BIN_W'(val);
      e.err = 1'b0;
`endif
      return e;
   endfunction

   // Caller sits at a negedge; start is sampled on the following posedge.
   task automatic kick(input logic [4*NDIG-1:0] v);
      bcd   = v;
      start = 1'b1;
      sb.push_back(model(v));
      @(negedge clk);
      start   = 1'b0;
      t_start = cyc;
   endtask

   task automatic wait_done(input int budget, output bit seen, output int busy_lo);
      seen    = 1'b0;
      busy_lo = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            if (busy !== 1'b1) busy_lo++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({busy, done, err, bin} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got busy=%b done=%b err=%b bin=%0d want all 0", busy, done, err, bin);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_single;
      bit   seen;
      int   blo;
      exp_t e;
      kick(12'h999);
      wait_done(40, seen, blo);
      e = sb.pop_front();
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL single_timeout got no done want done");
      end
      n_chk++;
      if ((cyc - t_start) != 20) begin
         n_fail++;
         $display("FAIL single_latency got %0d want 20", cyc - t_start);
      end
      n_chk++;
      if (bin !== e.bin || err !== e.err) begin
         n_fail++;
         $display("FAIL single_result got bin=%0d err=%b want bin=%0d err=%b", bin, err, e.bin, e.err);
      end
      n_chk++;
      if (blo != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy got low_cycles=%0d busy_at_done=%b want 0 0", blo, busy);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || bin !== e.bin) begin
         n_fail++;
         $display("FAIL single_pulse got done=%b bin=%0d want done=0 bin=%0d", done, bin, e.bin);
      end
   endtask

   task automatic test_back_to_back;
      bit   seen;
      int   blo, t1;
      exp_t e;
      kick(12'h000);
      wait_done(40, seen, blo);
      t1 = cyc;
      e  = sb.pop_front();
      n_chk++;
      if (!seen || bin !== e.bin || err !== e.err) begin
         n_fail++;
         $display("FAIL b2b_first got seen=%b bin=%0d want seen=1 bin=%0d", seen, bin, e.bin);
      end
      kick(12'h255);
      wait_done(40, seen, blo);
      e = sb.pop_front();
      n_chk++;
      if (!seen || bin !== e.bin || err !== e.err) begin
         n_fail++;
         $display("FAIL b2b_second got seen=%b bin=%0d want seen=1 bin=%0d", seen, bin, e.bin);
      end
      n_chk++;
      if ((cyc - t1) != 21) begin
         n_fail++;
         $display("FAIL b2b_spacing got %0d want 21", cyc - t1);
      end
   endtask

   task automatic test_sweep;
      bit                seen;
      int                blo;
      exp_t              e;
      logic [4*NDIG-1:0] b;
      for (int v = 0; v < 1000; v++) begin
         b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         kick(b);
         wait_done(40, seen, blo);
         e = sb.pop_front();
         n_chk++;
         if (!seen || bin !== e.bin || err !== e.err || blo != 0 || busy !== 1'b0 || (cyc - t_start) != 20) begin
            n_fail++;
            $display("FAIL sweep_%0d got bin=%0d err=%b lat=%0d busy_low=%0d want bin=%0d err=%b lat=20 busy_low=0",
                     v, bin, err, cyc - t_start, blo, e.bin, e.err);
         end
      end
   endtask

   task automatic test_start_while_busy;
      bit   seen;
      int   blo, d0;
      exp_t e;
      @(negedge clk);
      d0 = done_cnt;
      kick(12'h128);
      start = 1'b1;
      bcd   = 12'h777;
      wait_done(40, seen, blo);
      start = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if (!seen || bin !== e.bin || (cyc - t_start) != 20) begin
         n_fail++;
         $display("FAIL busy_start_result got bin=%0d lat=%0d want bin=%0d lat=20", bin, cyc - t_start, e.bin);
      end
      repeat (30) @(negedge clk);
      n_chk++;
      if ((done_cnt - d0) != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_count got dones=%0d busy=%b want 1 0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid;
      bit   seen;
      int   blo, d0;
      exp_t e;
      kick(12'h500);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      d0 = done_cnt;
      n_chk++;
      if (busy !== 1'b0 || bin !== '0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state got busy=%b bin=%0d done=%b want 0 0 0", busy, bin, done);
      end
      repeat (30) @(negedge clk);
      n_chk++;
      if (done_cnt != d0) begin
         n_fail++;
         $display("FAIL midreset_no_done got %0d dones want 0", done_cnt - d0);
      end
      kick(12'h042);
      wait_done(40, seen, blo);
      e = sb.pop_front();
      n_chk++;
      if (!seen || bin !== e.bin || err !== e.err) begin
         n_fail++;
         $display("FAIL midreset_next got seen=%b bin=%0d want seen=1 bin=%0d", seen, bin, e.bin);
      end
   endtask

`ifdef DEC_TO_BIN_RANGE_CHECK_EN
   task automatic test_range_check;
      bit   seen;
      int   blo;
      exp_t e;
      @(negedge clk);
      kick(12'h1A5);
      wait_done(10, seen, blo);
      e = sb.pop_front();
      n_chk++;
      if (!seen || (cyc - t_start) != 1 || err !== 1'b1 || bin !== e.bin) begin
         n_fail++;
         $display("FAIL range_bad got lat=%0d err=%b bin=%0d want lat=1 err=1 bin=0", cyc - t_start, err, bin);
      end
      kick(12'h105);
      wait_done(40, seen, blo);
      e = sb.pop_front();
      n_chk++;
      if (!seen || (cyc - t_start) != 20 || err !== 1'b0 || bin !== e.bin) begin
         n_fail++;
         $display("FAIL range_good got lat=%0d err=%b bin=%0d want lat=20 err=0 bin=%0d", cyc - t_start, err, bin, e.bin);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_sweep();
      test_start_while_busy();
      test_reset_mid();
`ifdef DEC_TO_BIN_RANGE_CHECK_EN
      test_range_check();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
